// File: rtl/sr_ff_bank.sv
`default_nettype none
// ============================================================================
// Module      : sr_ff_bank
// Description : Bank of N clocked SR flag registers with per-channel enable,
//               a parameter-selected S&R response, registered rise/fall
//               pulses, sticky per-channel conflict flags and a saturating
//               conflict-cycle counter.
// Revision    : 1.0 - initial release
// ============================================================================
module sr_ff_bank #(
  parameter int           N         = 4,
  parameter logic [1:0]   MODE      = 2'd1,
  parameter logic [N-1:0] RESET_VAL = {N{1'b0}},
  parameter int           CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     S,
  input  logic [N-1:0]     R,
  input  logic [N-1:0]     En,
  input  logic             clr_err,
  output logic [N-1:0]     Q,
  output logic [N-1:0]     Qbar,
  output logic [N-1:0]     rise,
  output logic [N-1:0]     fall,
  output logic [N-1:0]     conflict_flag,
  output logic [CNT_W-1:0] conflict_cnt
);

  localparam logic [1:0]       C_MODE_HOLD    = 2'd0;
  localparam logic [1:0]       C_MODE_SET_DOM = 2'd1;
  localparam logic [1:0]       C_MODE_RST_DOM = 2'd2;
  localparam logic [1:0]       C_MODE_TOGGLE  = 2'd3;
  localparam logic [CNT_W-1:0] C_CNT_MAX      = {CNT_W{1'b1}};

  logic [N-1:0]     q_q, q_d;
  logic [N-1:0]     rise_q, rise_d;
  logic [N-1:0]     fall_q, fall_d;
  logic [N-1:0]     flag_q, flag_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N-1:0]     w_conflict;
  logic [CNT_W-1:0] w_cnt_base;

  // Per-channel next state; a disabled channel ignores S and R entirely.
  always_comb begin
    q_d = q_q;
    for (int i = 0; i < N; i++) begin
      if (En[i]) begin
        unique case ({S[i], R[i]})
          2'b10: q_d[i] = 1'b1;
          2'b01: q_d[i] = 1'b0;
          2'b11: begin
            unique case (MODE)
              C_MODE_HOLD:    q_d[i] = q_q[i];
              C_MODE_SET_DOM: q_d[i] = 1'b1;
              C_MODE_RST_DOM: q_d[i] = 1'b0;
              C_MODE_TOGGLE:  q_d[i] = ~q_q[i];
              default:        q_d[i] = q_q[i];
            endcase
          end
          default: q_d[i] = q_q[i];
        endcase
      end
    end
  end

  // Edge pulses compare the value about to be stored with the current one.
  always_comb begin
    rise_d = q_d & ~q_q;
    fall_d = ~q_d & q_q;
  end

  // Conflict bookkeeping: clr_err wipes history first, then this cycle's
  // conflicts are merged in, so a simultaneous clear never loses an event.
  always_comb begin
    w_conflict = En & S & R;
    flag_d     = (clr_err ? {N{1'b0}} : flag_q) | w_conflict;
    w_cnt_base = clr_err ? {CNT_W{1'b0}} : cnt_q;
    cnt_d      = w_cnt_base;
    if ((|w_conflict) && (w_cnt_base != C_CNT_MAX)) begin
      cnt_d = w_cnt_base + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // State registers; rst discards the cycle's inputs and suppresses pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_q    <= RESET_VAL;
      rise_q <= {N{1'b0}};
      fall_q <= {N{1'b0}};
      flag_q <= {N{1'b0}};
      cnt_q  <= {CNT_W{1'b0}};
    end else begin
      q_q    <= q_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      flag_q <= flag_d;
      cnt_q  <= cnt_d;
    end
  end

  assign Q             = q_q;
  assign Qbar          = ~q_q;
  assign rise          = rise_q;
  assign fall          = fall_q;
  assign conflict_flag = flag_q;
  assign conflict_cnt  = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_sr_ff_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_sr_ff_bank
// Description : Directed self-checking bench for sr_ff_bank. Five instances
//               share stimulus: one per MODE (RESET_VAL=0) plus a TOGGLE
//               instance with RESET_VAL=1010, all with N=4, CNT_W=2.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sr_ff_bank;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] S, R, En;
  logic       clr_err;

  // Index: 0=HOLD 1=SET_DOM 2=RST_DOM 3=TOGGLE 4=TOGGLE(RESET_VAL=1010)
  logic [3:0] q   [5];
  logic [3:0] qb  [5];
  logic [3:0] ri  [5];
  logic [3:0] fa  [5];
  logic [3:0] cf  [5];
  logic [1:0] cnt [5];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sr_ff_bank #(.N(4), .MODE(2'd0), .RESET_VAL(4'b0000), .CNT_W(2)) u_hold (
    .clk(clk), .rst(rst), .S(S), .R(R), .En(En), .clr_err(clr_err),
    .Q(q[0]), .Qbar(qb[0]), .rise(ri[0]), .fall(fa[0]),
    .conflict_flag(cf[0]), .conflict_cnt(cnt[0]));

  sr_ff_bank #(.N(4), .MODE(2'd1), .RESET_VAL(4'b0000), .CNT_W(2)) u_set (
    .clk(clk), .rst(rst), .S(S), .R(R), .En(En), .clr_err(clr_err),
    .Q(q[1]), .Qbar(qb[1]), .rise(ri[1]), .fall(fa[1]),
    .conflict_flag(cf[1]), .conflict_cnt(cnt[1]));

  sr_ff_bank #(.N(4), .MODE(2'd2), .RESET_VAL(4'b0000), .CNT_W(2)) u_rst (
    .clk(clk), .rst(rst), .S(S), .R(R), .En(En), .clr_err(clr_err),
    .Q(q[2]), .Qbar(qb[2]), .rise(ri[2]), .fall(fa[2]),
    .conflict_flag(cf[2]), .conflict_cnt(cnt[2]));

  sr_ff_bank #(.N(4), .MODE(2'd3), .RESET_VAL(4'b0000), .CNT_W(2)) u_tog (
    .clk(clk), .rst(rst), .S(S), .R(R), .En(En), .clr_err(clr_err),
    .Q(q[3]), .Qbar(qb[3]), .rise(ri[3]), .fall(fa[3]),
    .conflict_flag(cf[3]), .conflict_cnt(cnt[3]));

  sr_ff_bank #(.N(4), .MODE(2'd3), .RESET_VAL(4'b1010), .CNT_W(2)) u_tr (
    .clk(clk), .rst(rst), .S(S), .R(R), .En(En), .clr_err(clr_err),
    .Q(q[4]), .Qbar(qb[4]), .rise(ri[4]), .fall(fa[4]),
    .conflict_flag(cf[4]), .conflict_cnt(cnt[4]));

  // Single comparison point: counts every check, reports any mismatch.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle 1ns past it before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] en, input logic [3:0] s, input logic [3:0] r, input logic clr);
    En = en; S = s; R = r; clr_err = clr;
  endtask

  initial begin
    rst = 1'b1;
    drive(4'h0, 4'h0, 4'h0, 1'b0);

    // ---- 1: reset state, then set channels 0 and 2
    tick();
    check("rst_q",    32'(q[1]),   32'h0);
    check("rst_qbar", 32'(qb[1]),  32'hF);
    check("rst_flag", 32'(cf[1]),  32'h0);
    check("rst_cnt",  32'(cnt[1]), 32'h0);
    check("rst_rise", 32'(ri[1]),  32'h0);
    rst = 1'b0;
    drive(4'hF, 4'h5, 4'h0, 1'b0);
    tick();
    check("set_q",    32'(q[1]),  32'h5);
    check("set_rise", 32'(ri[1]), 32'h5);
    check("set_qbar", 32'(qb[1]), 32'hA);
    // set while already set: no further pulse
    tick();
    check("reset_q2",   32'(q[1]),  32'h5);
    check("rise_once",  32'(ri[1]), 32'h0);

    // ---- 2: disabled channels ignore S
    drive(4'h0, 4'hF, 4'h0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("dis_q",    32'(q[1]),  32'h5);
      check("dis_rise", 32'(ri[1]), 32'h0);
    end
    // enabling only ch1 (already 0): nothing changes
    drive(4'h2, 4'h0, 4'hF, 1'b0);
    tick();
    check("ch1_clr_q",    32'(q[1]),  32'h5);
    check("ch1_clr_fall", 32'(fa[1]), 32'h0);
    // enabling only ch2 (currently 1): only ch2 falls
    drive(4'h4, 4'h0, 4'hF, 1'b0);
    tick();
    check("ch2_clr_q",    32'(q[1]),  32'h1);
    check("ch2_clr_fall", 32'(fa[1]), 32'h4);
    check("ch2_clr_rise", 32'(ri[1]), 32'h0);

    // ---- 3: bring all MODE instances to 0011, then two S&R cycles
    drive(4'hF, 4'h3, 4'h0, 1'b0);
    tick();
    check("pre_hold", 32'(q[0]), 32'h3);
    check("pre_tog",  32'(q[3]), 32'h3);
    drive(4'hF, 4'hF, 4'hF, 1'b0);
    tick();
    check("m0_c1", 32'(q[0]), 32'h3);
    check("m1_c1", 32'(q[1]), 32'hF);
    check("m2_c1", 32'(q[2]), 32'h0);
    check("m3_c1", 32'(q[3]), 32'hC);
    check("m3_c1_rise", 32'(ri[3]), 32'hC);
    check("m3_c1_fall", 32'(fa[3]), 32'h3);
    check("m0_c1_flag", 32'(cf[0]), 32'hF);
    tick();
    check("m0_c2", 32'(q[0]), 32'h3);
    check("m1_c2", 32'(q[1]), 32'hF);
    check("m2_c2", 32'(q[2]), 32'h0);
    check("m3_c2", 32'(q[3]), 32'h3);
    check("all_conf_cnt", 32'(cnt[1]), 32'h2);

    // ---- 4: clear, then ch2 conflict for 5 cycles, counter saturates at 3
    drive(4'h0, 4'h0, 4'h0, 1'b1);
    tick();
    check("clr_flag", 32'(cf[1]),  32'h0);
    check("clr_cnt",  32'(cnt[1]), 32'h0);
    drive(4'h4, 4'h4, 4'h4, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      tick();
      check("sat_cnt", 32'(cnt[1]), (k < 3) ? 32'(k) : 32'h3);
    end
    check("sat_flag", 32'(cf[1]), 32'h4);
    drive(4'h0, 4'h0, 4'h0, 1'b1);
    tick();
    check("clr2_flag", 32'(cf[1]),  32'h0);
    check("clr2_cnt",  32'(cnt[1]), 32'h0);

    // ---- 5: clear coinciding with a new conflict on ch0
    drive(4'h8, 4'h8, 4'h8, 1'b0);
    tick();
    check("c3_flag", 32'(cf[1]),  32'h8);
    check("c3_cnt",  32'(cnt[1]), 32'h1);
    drive(4'h1, 4'h1, 4'h1, 1'b1);
    tick();
    check("clrnew_flag", 32'(cf[1]),  32'h1);
    check("clrnew_cnt",  32'(cnt[1]), 32'h1);
    // many channels conflicting in one cycle count once
    drive(4'hF, 4'hF, 4'hF, 1'b0);
    tick();
    check("multi_cnt",  32'(cnt[1]), 32'h2);
    check("multi_flag", 32'(cf[1]),  32'hF);

    // ---- 6: TOGGLE with RESET_VAL=1010, rst mid-run
    rst = 1'b1;
    drive(4'h0, 4'h0, 4'h0, 1'b0);
    tick();
    check("tr_rst_q", 32'(q[4]), 32'hA);
    rst = 1'b0;
    drive(4'hF, 4'hF, 4'hF, 1'b0);
    tick();
    check("tr_t1", 32'(q[4]), 32'h5);
    tick();
    check("tr_t2", 32'(q[4]), 32'hA);
    rst = 1'b1;
    tick();
    check("tr_mid_q",    32'(q[4]),   32'hA);
    check("tr_mid_rise", 32'(ri[4]),  32'h0);
    check("tr_mid_fall", 32'(fa[4]),  32'h0);
    check("tr_mid_cnt",  32'(cnt[4]), 32'h0);
    check("tr_mid_qbar", 32'(qb[4]),  32'h5);
    rst = 1'b0;
    tick();
    check("tr_res_q",    32'(q[4]),  32'h5);
    check("tr_res_rise", 32'(ri[4]), 32'h5);
    check("tr_res_fall", 32'(fa[4]), 32'hA);
    check("tr_res_cnt",  32'(cnt[4]), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
